// File: rtl/aes128_encrypt_iter_if.sv
// Start/data/result bundle for aes128_encrypt_iter.
// AES_LAST_ROUND_KEY_EN adds the lastRoundKey result word.
interface aes128_encrypt_iter_if;
  logic         encryptEnable;
  logic [127:0] key;
  logic [127:0] inputData;
  logic [127:0] outputData;
  logic         busy;
  logic         done;
`ifdef AES_LAST_ROUND_KEY_EN
  logic [127:0] lastRoundKey;

  modport master (output encryptEnable, key, inputData,
                  input  outputData, busy, done, lastRoundKey);
  modport slave  (input  encryptEnable, key, inputData,
                  output outputData, busy, done, lastRoundKey);
`else
  modport master (output encryptEnable, key, inputData,
                  input  outputData, busy, done);
  modport slave  (input  encryptEnable, key, inputData,
                  output outputData, busy, done);
`endif
endinterface

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Optional macro AES_LAST_ROUND_KEY_EN exports the final round key as lastRoundKey.
module aes128_encrypt_iter (
  input  logic                  clk,
  input  logic                  rst,
  aes128_encrypt_iter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k of a block sits at [127-8k -: 8]; k = 4*column + row.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, rot, sw;
    rot = {rk[23:0], rk[31:24]};
    sw  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    w0  = rk[127:96] ^ sw ^ {rcon, 24'h0};
    w1  = rk[95:64] ^ w0;
    w2  = rk[63:32] ^ w1;
    w3  = rk[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  fsm_t         r_fsm;
  logic [127:0] r_state, r_rk, r_out;
  logic [7:0]   r_rcon;
  logic [3:0]   r_rnd;
  logic         r_busy, r_done;
  logic [127:0] w_nk, w_sr, w_round, w_last;

  always_comb begin
    w_nk    = key_expand(r_rk, r_rcon);
    w_sr    = shift_rows(sub_bytes(r_state));
    w_round = mix_columns(w_sr) ^ w_nk;
    w_last  = w_sr ^ w_nk;
  end

`ifdef AES_LAST_ROUND_KEY_EN
  logic [127:0] r_lrk;
  always_ff @(posedge clk) begin
    if (rst)                r_lrk <= '0;
    else if (r_fsm == FINAL) r_lrk <= w_nk;
  end
  assign bus.lastRoundKey = r_lrk;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_rk    <= '0;
      r_rcon  <= '0;
      r_rnd   <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        IDLE: if (bus.encryptEnable) begin
          r_state <= bus.inputData ^ bus.key;
          r_rk    <= bus.key;
          r_rcon  <= 8'h01;
          r_rnd   <= 4'd1;
          r_busy  <= 1'b1;
          r_fsm   <= ROUND;
        end
        ROUND: begin
          r_state <= w_round;
          r_rk    <= w_nk;
          r_rcon  <= xtime(r_rcon);
          r_rnd   <= r_rnd + 4'd1;
          if (r_rnd == 4'd9) r_fsm <= FINAL;
        end
        FINAL: begin
          r_out  <= w_last;
          r_rk   <= w_nk;
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_fsm  <= IDLE;
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign bus.outputData = r_out;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Directed FIPS-197 vector bench for aes128_encrypt_iter (App. B and C.1).
module tb_aes128_encrypt_iter;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] LB  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] LC  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  aes128_encrypt_iter_if bus ();
  aes128_encrypt_iter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] c, input logic [127:0] lrk);
    int busy_cnt = 0;
    int early    = 0;
    @(negedge clk);
    bus.encryptEnable = 1'b1; bus.key = k; bus.inputData = p;
    @(posedge clk); #1;
    bus.encryptEnable = 1'b0;
    if (bus.busy) busy_cnt++;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i < 10) begin
        if (bus.busy) busy_cnt++;
        if (bus.done) early++;
      end
    end
    check({tag, "_busycnt"}, 128'(busy_cnt), 128'd10);
    check({tag, "_early"},   128'(early),    128'd0);
    check({tag, "_done"},    128'(bus.done), 128'd1);
    check({tag, "_busy0"},   128'(bus.busy), 128'd0);
    check({tag, "_out"},     bus.outputData, c);
`ifdef AES_LAST_ROUND_KEY_EN
    check({tag, "_lrk"},     bus.lastRoundKey, lrk);
`else
    if (lrk == 128'h0) check({tag, "_lrkarg"}, 128'h1, 128'h0);
`endif
    @(posedge clk); #1;
    check({tag, "_donepulse"}, 128'(bus.done), 128'd0);
    check({tag, "_hold"},      bus.outputData, c);
  endtask

  initial begin
    int dcnt, dat, d1, d2;
    logic [127:0] o1, o2;
    bus.encryptEnable = 1'b0; bus.key = '0; bus.inputData = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out",  bus.outputData, 128'h0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    rst = 1'b0;

    run_block("appB", KB, PB, CB, LB);
    run_block("appC", KC, PC, CC, LC);

    // New inputs and a start pulse mid-operation must not disturb the block in flight.
    @(negedge clk);
    bus.encryptEnable = 1'b1; bus.key = KB; bus.inputData = PB;
    @(posedge clk); #1;
    bus.encryptEnable = 1'b0; bus.key = '1; bus.inputData = '1;
    dcnt = 0; dat = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 4) bus.encryptEnable = 1'b1;
      @(posedge clk); #1;
      bus.encryptEnable = 1'b0;
      if (bus.done) begin dcnt++; dat = i; end
    end
    check("stab_dcnt", 128'(dcnt), 128'd1);
    check("stab_dat",  128'(dat),  128'd10);
    check("stab_out",  bus.outputData, CB);

    // Back-to-back with encryptEnable held high.
    @(negedge clk);
    bus.encryptEnable = 1'b1; bus.key = KB; bus.inputData = PB;
    @(posedge clk); #1;
    d1 = 0; d2 = 0; o1 = '0; o2 = '0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (d1 == 0) begin
          d1 = i; o1 = bus.outputData; bus.key = KC; bus.inputData = PC;
        end else if (d2 == 0) begin
          d2 = i; o2 = bus.outputData;
        end
      end
    end
    bus.encryptEnable = 1'b0;
    check("b2b_d1",  128'(d1), 128'd10);
    check("b2b_gap", 128'(d2 - d1), 128'd11);
    check("b2b_o1",  o1, CB);
    check("b2b_o2",  o2, CC);
    repeat (12) @(posedge clk);

    // Reset asserted for one edge in the middle of an operation.
    @(negedge clk);
    bus.encryptEnable = 1'b1; bus.key = KB; bus.inputData = PB;
    @(posedge clk); #1;
    bus.encryptEnable = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_out",  bus.outputData, 128'h0);
    check("mrst_busy", 128'(bus.busy), 128'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dcnt++;
    end
    check("mrst_quiet", 128'(dcnt), 128'd0);
    run_block("post_rst", KC, PC, CC, LC);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
